// File: rtl/axi4lite_sram_slv.sv
// AXI4-Lite slave fronting a single-port byte-writable SRAM, one outstanding transfer per channel.
// Optional out-of-range SLVERR reporting is enabled by defining SRAM_RANGE_CHK_EN.
module axi4lite_sram_slv #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready
);
    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned LSB   = $clog2(BYTES);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic { W_IDLE, W_RESP } wstate_t;
    typedef enum logic { R_IDLE, R_DATA } rstate_t;

    wstate_t wstate;
    rstate_t rstate;
    logic    prio_rd;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0] widx;
    logic [IDX_W-1:0] ridx;
    logic             w_oor;
    logic             r_oor;
    logic             write_req;
    logic             read_req;
    logic             write_grant;
    logic             read_grant;
    logic             unused_addr_bits;

    assign widx = awaddr[LSB +: IDX_W];
    assign ridx = araddr[LSB +: IDX_W];
    assign unused_addr_bits = ^{awaddr, araddr};

`ifdef SRAM_RANGE_CHK_EN
    assign w_oor = (awaddr >> (LSB + IDX_W)) != '0;
    assign r_oor = (araddr >> (LSB + IDX_W)) != '0;
`else
    assign w_oor = 1'b0;
    assign r_oor = 1'b0;
`endif

    // rst_n gates the requests so no ready can rise while reset is held
    assign write_req   = rst_n && (wstate == W_IDLE) && awvalid && wvalid;
    assign read_req    = rst_n && (rstate == R_IDLE) && arvalid;
    assign write_grant = write_req && (!read_req || !prio_rd);
    assign read_grant  = read_req && (!write_req || prio_rd);

    assign awready = write_grant;
    assign wready  = write_grant;
    assign arready = read_grant;

    always_ff @(posedge clk) begin
        if (write_grant && !w_oor) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (wstrb[i]) begin
                    mem[widx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate  <= W_IDLE;
            rstate  <= R_IDLE;
            prio_rd <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            rvalid  <= 1'b0;
            rresp   <= 2'b00;
            rdata   <= '0;
        end else begin
            if (write_req && read_req) begin
                prio_rd <= !prio_rd;
            end

            case (wstate)
                W_IDLE: begin
                    if (write_grant) begin
                        wstate <= W_RESP;
                        bvalid <= 1'b1;
                        bresp  <= w_oor ? 2'b10 : 2'b00;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        wstate <= W_IDLE;
                        bvalid <= 1'b0;
                    end
                end
            endcase

            case (rstate)
                R_IDLE: begin
                    if (read_grant) begin
                        rstate <= R_DATA;
                        rvalid <= 1'b1;
                        rdata  <= r_oor ? '0 : mem[ridx];
                        rresp  <= r_oor ? 2'b10 : 2'b00;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rstate <= R_IDLE;
                        rvalid <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi4lite_sram_slv.sv
// Self-checking bench for axi4lite_sram_slv (DEPTH=16) against an array model of the word store.
// Expectations follow SRAM_RANGE_CHK_EN when it is defined for the build.
module tb_axi4lite_sram_slv;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int total = 0;
    int bad   = 0;
    logic [31:0] model [16];

    axi4lite_sram_slv #(.DATA_W(32), .ADDR_W(32), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Bus-level transfer; timely=0 if the handshake or response latency was wrong.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output bit timely);
        int n;
        timely = 1'b1;
        @(posedge clk); #1;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!awready) begin
            n++;
            if (n > 50) begin timely = 1'b0; break; end
            @(negedge clk);
        end
        if (wready !== 1'b1) timely = 1'b0;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        if (bvalid !== 1'b1) timely = 1'b0;
        resp = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        if (bvalid !== 1'b0) timely = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output bit timely);
        int n;
        timely = 1'b1;
        @(posedge clk); #1;
        araddr = addr; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!arready) begin
            n++;
            if (n > 50) begin timely = 1'b0; break; end
            @(negedge clk);
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        if (rvalid !== 1'b1) timely = 1'b0;
        data = rdata;
        resp = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        if (rvalid !== 1'b0) timely = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({awready, wready, arready} !== 3'b000) begin
            bad++; $display("FAIL reset_ready: got %b want 000", {awready, wready, arready});
        end
        total++;
        if ({bvalid, rvalid} !== 2'b00) begin
            bad++; $display("FAIL reset_valid: got %b want 00", {bvalid, rvalid});
        end
        total++;
        if (rdata !== 32'h0 || bresp !== 2'b00 || rresp !== 2'b00) begin
            bad++; $display("FAIL reset_data: rdata=%h bresp=%b rresp=%b want 0", rdata, bresp, rresp);
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [1:0]  resp;
        logic [31:0] d;
        bit          ok;
        axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, resp, ok);
        model[4] = 32'hDEAD_BEEF;
        total++;
        if (!ok || resp !== 2'b00) begin
            bad++; $display("FAIL basic_write: timely=%0d bresp=%b want 1/00", ok, resp);
        end
        axi_read(32'h10, d, resp, ok);
        total++;
        if (!ok || d !== 32'hDEAD_BEEF || resp !== 2'b00) begin
            bad++; $display("FAIL basic_read: timely=%0d rdata=%h rresp=%b want 1/deadbeef/00", ok, d, resp);
        end
    endtask

    task automatic test_strobe();
        logic [1:0]  resp;
        logic [31:0] d;
        bit          ok;
        axi_write(32'h20, 32'h1122_3344, 4'hF, resp, ok);
        axi_write(32'h20, 32'hAABB_CCDD, 4'h5, resp, ok);
        model[8] = 32'h1122_3344;
        model[8] = 32'h11BB_33DD;
        axi_read(32'h20, d, resp, ok);
        total++;
        if (!ok || d !== 32'h11BB_33DD) begin
            bad++; $display("FAIL strobe_merge: timely=%0d rdata=%h want 11bb33dd", ok, d);
        end
    endtask

    task automatic test_random();
        logic [1:0]  resp;
        logic [31:0] d, data, addr;
        logic [3:0]  strb;
        bit          ok;
        int          idx;
        for (int i = 0; i < 16; i++) begin
            data = $urandom;
            axi_write(i * 4, data, 4'hF, resp, ok);
            model[i] = data;
        end
        for (int i = 0; i < 40; i++) begin
            idx  = $urandom_range(0, 15);
            addr = idx * 4 + $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                axi_write(addr, data, strb, resp, ok);
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
                total++;
                if (!ok || resp !== 2'b00) begin
                    bad++; $display("FAIL rand_write[%0d]: timely=%0d bresp=%b want 1/00", i, ok, resp);
                end
            end else begin
                axi_read(addr, d, resp, ok);
                total++;
                if (!ok || d !== model[idx] || resp !== 2'b00) begin
                    bad++; $display("FAIL rand_read[%0d]: addr=%h rdata=%h want %h timely=%0d", i, addr, d, model[idx], ok);
                end
            end
        end
    endtask

    task automatic test_contention();
        logic        exp_w, exp_r;
        logic [31:0] wd;
        @(posedge clk); #1;
        rst_n = 1'b0;
        awaddr = 32'h4; araddr = 32'h4; wstrb = 4'hF; wdata = 32'hC0DE_0000;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wdata = 32'hC0DE_0000 + k;
            @(negedge clk);
            exp_w = (k % 2 == 0);
            exp_r = (k % 2 == 1);
            total++;
            if (awready !== exp_w || wready !== exp_w || arready !== exp_r) begin
                bad++; $display("FAIL grant_cycle%0d: aw/w/ar=%b%b%b want %b%b%b", k, awready, wready, arready, exp_w, exp_w, exp_r);
            end
            if (k >= 2 && k % 2 == 0) begin
                total++;
                if (rvalid !== 1'b1 || rdata !== 32'hC0DE_0000 + k - 2) begin
                    bad++; $display("FAIL grant_rdata%0d: rvalid=%b rdata=%h want 1/%h", k, rvalid, rdata, 32'hC0DE_0000 + k - 2);
                end
            end
            @(posedge clk); #1;
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        model[1] = 32'hC0DE_0006;
        @(negedge clk);
        total++;
        if (rvalid !== 1'b1 || rdata !== 32'hC0DE_0006) begin
            bad++; $display("FAIL grant_last_read: rvalid=%b rdata=%h want 1/c0de0006", rvalid, rdata);
        end
        repeat (2) @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            wd = $urandom;
            awaddr = 32'h8; araddr = 32'h8; wdata = wd;
            awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
            @(negedge clk);
            exp_w = (c == 1);
            total++;
            if (awready !== exp_w || arready !== !exp_w) begin
                bad++; $display("FAIL contest%0d: aw/ar=%b%b want %b%b", c, awready, arready, exp_w, !exp_w);
            end
            if (exp_w) model[2] = wd;
            @(posedge clk); #1;
            awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
            repeat (3) @(posedge clk);
        end
        #1;
        bready = 1'b0; rready = 1'b0;
    endtask

    task automatic test_stall();
        @(posedge clk); #1;
        araddr = 32'hC; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        total++;
        if (arready !== 1'b1) begin
            bad++; $display("FAIL stall_ar: arready=%b want 1", arready);
        end
        @(posedge clk); #1;
        araddr = 32'h14;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (rvalid !== 1'b1 || rdata !== model[3] || arready !== 1'b0) begin
                bad++; $display("FAIL stall_hold%0d: rvalid=%b rdata=%h arready=%b want 1/%h/0", k, rvalid, rdata, arready, model[3]);
            end
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(negedge clk);
        total++;
        if (rvalid !== 1'b1 || arready !== 1'b0) begin
            bad++; $display("FAIL stall_rhs: rvalid=%b arready=%b want 1/0", rvalid, arready);
        end
        @(posedge clk); #1;
        rready = 1'b0;
        @(negedge clk);
        total++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            bad++; $display("FAIL stall_reaccept: arready=%b rvalid=%b want 1/0", arready, rvalid);
        end
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        @(negedge clk);
        total++;
        if (rvalid !== 1'b1 || rdata !== model[5]) begin
            bad++; $display("FAIL stall_second: rvalid=%b rdata=%h want 1/%h", rvalid, rdata, model[5]);
        end
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic test_range();
        logic [1:0]  resp;
        logic [31:0] d;
        bit          ok;
        logic [1:0]  exp_resp;
`ifdef SRAM_RANGE_CHK_EN
        exp_resp = 2'b10;
`else
        exp_resp = 2'b00;
        model[0] = 32'h5555_AAAA;
`endif
        axi_write(32'h40, 32'h5555_AAAA, 4'hF, resp, ok);
        total++;
        if (!ok || resp !== exp_resp) begin
            bad++; $display("FAIL range_bresp: timely=%0d bresp=%b want 1/%b", ok, resp, exp_resp);
        end
        axi_read(32'h0, d, resp, ok);
        total++;
        if (!ok || d !== model[0] || resp !== 2'b00) begin
            bad++; $display("FAIL range_word0: rdata=%h rresp=%b want %h/00", d, resp, model[0]);
        end
        axi_read(32'h40, d, resp, ok);
`ifdef SRAM_RANGE_CHK_EN
        total++;
        if (!ok || d !== 32'h0 || resp !== 2'b10) begin
            bad++; $display("FAIL range_read: rdata=%h rresp=%b want 0/10", d, resp);
        end
`else
        total++;
        if (!ok || d !== model[0] || resp !== 2'b00) begin
            bad++; $display("FAIL alias_read: rdata=%h rresp=%b want %h/00", d, resp, model[0]);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [1:0]  resp;
        logic [31:0] d, wd;
        bit          ok;
        wd = $urandom;
        @(posedge clk); #1;
        awaddr = 32'h18; wdata = wd; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        total++;
        if (awready !== 1'b1) begin
            bad++; $display("FAIL rstmid_aw: awready=%b want 1", awready);
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        model[6] = wd;
        @(negedge clk);
        total++;
        if (bvalid !== 1'b1) begin
            bad++; $display("FAIL rstmid_bvalid: bvalid=%b want 1", bvalid);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bvalid !== 1'b0 || bresp !== 2'b00) begin
            bad++; $display("FAIL rstmid_async: bvalid=%b bresp=%b want 0/00", bvalid, bresp);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        axi_read(32'h18, d, resp, ok);
        total++;
        if (!ok || d !== wd) begin
            bad++; $display("FAIL rstmid_keep: rdata=%h want %h timely=%0d", d, wd, ok);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_random();
        test_contention();
        test_stall();
        test_range();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
